// File: rtl/serializer.sv
// Parallel-to-serial converter: takes NO_CH signed words through a valid/ready
// handshake and emits each as NO_CYC SER_BW-bit chunks, least-significant chunk first.
module serializer #(
  parameter int NO_CH  = 10,
  parameter int BW_IN  = 12,
  parameter int SER_BW = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vld_in,
  output logic                           rdy_in,
  input  logic [NO_CH-1:0][BW_IN-1:0]    data_in,
  output logic                           vld_out,
  output logic                           first_out,
  output logic                           last_out,
  output logic [NO_CH-1:0][SER_BW-1:0]   data_out
);

  localparam int NO_CYC = (BW_IN + SER_BW - 1) / SER_BW;
  localparam int PAD_BW = NO_CYC * SER_BW;
  localparam int CW     = (NO_CYC > 1) ? $clog2(NO_CYC) : 1;
  localparam int LAST   = NO_CYC - 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  if (SER_BW < 1 || SER_BW > BW_IN) begin : g_bad_param
    $error("serializer: SER_BW must satisfy 1 <= SER_BW <= BW_IN");
  end

  // Handshake: a word transfers on a rising edge where vld_in and rdy_in are
  // both high; data_in is ignored otherwise. Outputs have no backpressure.

  logic [0:0]                       state;
  logic [CW-1:0]                    cntr;
  logic [NO_CH-1:0][PAD_BW-1:0]     sh;
  logic [NO_CH-1:0][PAD_BW-1:0]     pad;
  logic                             at_last;
  logic                             accept;
  logic [CW-1:0]                    cntr_nxt;

  always_comb begin
    pad = '0;
    for (int c = 0; c < NO_CH; c++) begin
      for (int b = 0; b < PAD_BW; b++) begin
        pad[c][b] = data_in[c][(b < BW_IN) ? b : BW_IN - 1];
      end
    end
  end

  assign at_last  = (cntr == CW'(LAST));
  assign rdy_in   = !rst && ((state == IDLE) || at_last);
  assign accept   = vld_in && rdy_in;
  assign cntr_nxt = cntr + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cntr      <= '0;
      sh        <= '0;
      vld_out   <= 1'b0;
      first_out <= 1'b0;
      last_out  <= 1'b0;
      data_out  <= '0;
    end else if (accept) begin
      // Chunk 0 goes straight to the output register; the rest waits in sh.
      state     <= SHIFT;
      cntr      <= '0;
      vld_out   <= 1'b1;
      first_out <= 1'b1;
      last_out  <= (NO_CYC == 1);
      for (int c = 0; c < NO_CH; c++) begin
        data_out[c] <= pad[c][SER_BW-1:0];
        sh[c]       <= pad[c] >> SER_BW;
      end
    end else if (state == SHIFT && !at_last) begin
      cntr      <= cntr_nxt;
      first_out <= 1'b0;
      last_out  <= (cntr_nxt == CW'(LAST));
      for (int c = 0; c < NO_CH; c++) begin
        data_out[c] <= sh[c][SER_BW-1:0];
        sh[c]       <= sh[c] >> SER_BW;
      end
    end else if (state == SHIFT) begin
      state     <= IDLE;
      vld_out   <= 1'b0;
      first_out <= 1'b0;
      last_out  <= 1'b0;
    end
  end

endmodule
